serial_word_source: RTL and testbench

SERIAL_WORD_SOURCE -- requirements
Module: serial_word_source

---
 rtl/serial_word_source.sv | 149 ++++++++++++++
 tb/tb_serial_word_source.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_source.sv
// serial_word_source: 2-entry word FIFO feeding a parallel-to-serial shifter.
// Optional feature macro: SERIAL_WORD_SOURCE_PARITY_EN. When it is defined,
// each word is followed by one even-parity bit flagged on ParityBit.
module serial_word_source #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             DataValid,
  output logic             DataReady,
  input  logic             Enable,
  output logic             Sin,
  output logic             SinValid,
  output logic             Busy,
  output logic             ParityBit
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
    PARITY = 2'd2,
`endif
    SHIFT  = 2'd1
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0][WIDTH-1:0]   mem_q, mem_d;
  logic                    wr_q, wr_d;
  logic                    rd_q, rd_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    rdy_q, rdy_d;
  logic [WIDTH-1:0]        sh_q, sh_d;
  logic [CW-1:0]           bit_q, bit_d;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
  logic                    par_q, par_d;
`endif

  logic             push, pop, out_bit;
  logic [WIDTH-1:0] head;

  // rdy_q keeps DataReady low until the first edge after reset release
  assign rdy_d     = 1'b1;
  assign DataReady = rdy_q && (cnt_q != 2'd2);
  assign push      = DataValid && DataReady;
  assign head      = mem_q[rd_q];
  assign out_bit   = (MSB_FIRST != 0) ? sh_q[WIDTH-1] : sh_q[0];
  assign Busy      = (state_q != IDLE) || (cnt_q != 2'd0);

  // FIFO pointers and occupancy; a full FIFO never sees a push
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = DataIn;
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Shifter FSM: next state, shift register, bit counter and serial outputs
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    pop       = 1'b0;
    Sin       = 1'b0;
    SinValid  = 1'b0;
    ParityBit = 1'b0;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (Enable && (cnt_q != 2'd0)) pop = 1'b1;
      end
      SHIFT: begin
        Sin      = out_bit;
        SinValid = Enable;
        if (Enable) begin
          sh_d  = (MSB_FIRST != 0) ? (sh_q << 1) : (sh_q >> 1);
          bit_d = bit_q - 1'b1;
          if (bit_q == '0) begin
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
            state_d = PARITY;
`else
            if (cnt_q != 2'd0) pop = 1'b1;
            else               state_d = IDLE;
`endif
          end
        end
      end
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
      PARITY: begin
        Sin       = par_q;
        SinValid  = Enable;
        ParityBit = 1'b1;
        if (Enable) begin
          if (cnt_q != 2'd0) pop = 1'b1;
          else               state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Loading the FIFO head overrides whatever the state above chose
    if (pop) begin
      sh_d    = head;
      bit_d   = CW'(WIDTH-1);
      state_d = SHIFT;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  // State registers; reset discards buffered and in-flight words
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      mem_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= 2'd0;
      rdy_q   <= 1'b0;
      sh_q    <= '0;
      bit_q   <= '0;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_word_source.sv
// Bench for serial_word_source: two instances (MSB-first and LSB-first) share
// stimulus; a bit-queue reference model is checked every cycle, plus directed
// scenarios with constant expectations.
module tb_serial_word_source;
  localparam int W = 8;
`ifdef SERIAL_WORD_SOURCE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         Clk = 1'b0;
  logic         nReset;
  logic [W-1:0] DataIn;
  logic         DataValid, Enable;
  logic         rdy_m, sin_m, sv_m, busy_m, pb_m;
  logic         rdy_l, sin_l, sv_l, busy_l, pb_l;

  serial_word_source #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .Clk(Clk), .nReset(nReset), .DataIn(DataIn), .DataValid(DataValid),
    .DataReady(rdy_m), .Enable(Enable), .Sin(sin_m), .SinValid(sv_m),
    .Busy(busy_m), .ParityBit(pb_m));

  serial_word_source #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .Clk(Clk), .nReset(nReset), .DataIn(DataIn), .DataValid(DataValid),
    .DataReady(rdy_l), .Enable(Enable), .Sin(sin_l), .SinValid(sv_l),
    .Busy(busy_l), .ParityBit(pb_l));

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of accepted words, and per instance a queue of the
  // bits still to be emitted for the current word ({is_parity, value}).
  logic [W-1:0] mfifo[$];
  logic [1:0]   mbits_m[$];
  logic [1:0]   mbits_l[$];
  bit           mrdy;

  function automatic void mclear();
    mfifo.delete();
    mbits_m.delete();
    mbits_l.delete();
    mrdy = 1'b0;
  endfunction

  function automatic void mload(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      mbits_m.push_back({1'b0, w[W-1-i]});
      mbits_l.push_back({1'b0, w[i]});
    end
    if (PB != 0) begin
      mbits_m.push_back({1'b1, ^w});
      mbits_l.push_back({1'b1, ^w});
    end
  endfunction

  task automatic check_outputs();
    bit         act;
    logic [1:0] hm, hl;
    act = mbits_m.size() > 0;
    hm  = act ? mbits_m[0] : 2'b00;
    hl  = act ? mbits_l[0] : 2'b00;
    chk("sb_rdy_m",  32'(rdy_m),  32'(mrdy && (mfifo.size() < 2)));
    chk("sb_rdy_l",  32'(rdy_l),  32'(mrdy && (mfifo.size() < 2)));
    chk("sb_busy_m", 32'(busy_m), 32'(act || (mfifo.size() > 0)));
    chk("sb_busy_l", 32'(busy_l), 32'(act || (mfifo.size() > 0)));
    chk("sb_sv_m",   32'(sv_m),   32'(act && Enable));
    chk("sb_sv_l",   32'(sv_l),   32'(act && Enable));
    chk("sb_sin_m",  32'(sin_m),  32'(hm[0]));
    chk("sb_sin_l",  32'(sin_l),  32'(hl[0]));
    chk("sb_pb_m",   32'(pb_m),   32'(hm[1]));
    chk("sb_pb_l",   32'(pb_l),   32'(hl[1]));
  endtask

  // Model advances on each rising edge, is checked on each falling edge
  initial begin
    bit push;
    mclear();
    forever begin
      @(posedge Clk);
      if (!nReset) mclear();
      else begin
        push = DataValid && mrdy && (mfifo.size() < 2);
        if (Enable) begin
          if (mbits_m.size() > 0) begin
            void'(mbits_m.pop_front());
            void'(mbits_l.pop_front());
          end
          if (mbits_m.size() == 0 && mfifo.size() > 0) mload(mfifo.pop_front());
        end
        if (push) mfifo.push_back(DataIn);
        mrdy = 1'b1;
      end
      @(negedge Clk);
      if (!nReset) mclear();
      check_outputs();
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    DataIn    = w;
    DataValid = 1'b1;
    cyc();
    DataValid = 1'b0;
  endtask

  // Gather ntot valid bits from one instance: data bits and parity bits are
  // packed separately; first is the cycle of the first valid bit, span the
  // cycles from first to last valid bit.
  task automatic collect(input bit lsb, input int ntot, output logic [31:0] data,
                         output logic [31:0] pars, output int span, output int first);
    int got, c, last;
    logic sv, sn, pb;
    got = 0; c = 0; first = -1; last = -1; data = '0; pars = '0;
    while (got < ntot && c < 300) begin
      @(negedge Clk);
      c++;
      sv = lsb ? sv_l : sv_m;
      sn = lsb ? sin_l : sin_m;
      pb = lsb ? pb_l : pb_m;
      if (sv) begin
        if (first < 0) first = c;
        last = c;
        got++;
        if (pb) pars = {pars[30:0], sn};
        else    data = {data[30:0], sn};
      end
    end
    chk("collect_cnt", got, ntot);
    span = last - first + 1;
  endtask

  initial begin
    logic [31:0] d, p;
    int s, f, got, t, w;
    nReset = 1'b0; DataIn = '0; DataValid = 1'b0; Enable = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_rdy",  32'(rdy_m),  0);
    chk("rst_sv",   32'(sv_m),   0);
    chk("rst_busy", 32'(busy_m), 0);
    chk("rst_sin",  32'(sin_m),  0);
    chk("rst_pb",   32'(pb_m),   0);
    nReset = 1'b1;
    #3 chk("rdy_before_edge", 32'(rdy_m), 0);
    cyc();
    chk("rdy_after_edge", 32'(rdy_m), 1);
    Enable = 1'b1;

    // Single word MSB-first, two-edge latency, then idle
    push_word(8'hA5);
    collect(0, W+PB, d, p, s, f);
    chk("a5_data", d, 32'hA5);
    chk("a5_lat",  f, 2);
    chk("a5_span", s, W+PB);
    @(negedge Clk);
    chk("a5_idle_busy", 32'(busy_m), 0);
    chk("a5_idle_sv",   32'(sv_m),   0);

    // Back-to-back words, LSB-first, contiguous stream
    DataIn = 8'hF0; DataValid = 1'b1;
    cyc();
    DataIn = 8'h0F;
    cyc();
    DataValid = 1'b0;
    collect(1, 2*(W+PB), d, p, s, f);
    chk("f00f_data", d, 32'h0FF0);
    chk("f00f_span", s, 2*(W+PB));

    // Pause after three bits of C3
    push_word(8'hC3);
    got = 0; t = 0;
    while (got < 3 && t < 50) begin
      @(negedge Clk);
      t++;
      if (sv_m) got++;
    end
    chk("c3_pre", got, 3);
    cyc();
    Enable = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      chk("c3_pause_sv",   32'(sv_m),   0);
      chk("c3_pause_sin",  32'(sin_m),  0);
      chk("c3_pause_busy", 32'(busy_m), 1);
    end
    cyc();
    Enable = 1'b1;
    collect(0, 5+PB, d, p, s, f);
    chk("c3_rest_data", d, 32'h03);
    chk("c3_rest_span", s, 5+PB);

    // A shifting, then B, C fill the FIFO and D stalls until the next pop
    fork
      collect(0, 4*(W+PB), d, p, s, f);
      begin
        push_word(8'h3C);
        repeat (2) cyc();
        DataIn = 8'h96; DataValid = 1'b1;
        cyc();
        DataIn = 8'h5A;
        cyc();
        DataIn = 8'hE1;
        @(negedge Clk);
        chk("full_rdy", 32'(rdy_m), 0);
        w = 0;
        while (!rdy_m && w < 100) begin
          @(negedge Clk);
          w++;
        end
        chk("stall_seen", 32'(w > 0), 1);
        chk("stall_end",  32'(rdy_m), 1);
        @(posedge Clk);
        #1 DataValid = 1'b0;
      end
    join
    chk("four_data", d, 32'h3C965AE1);
    chk("four_span", s, 4*(W+PB));

`ifdef SERIAL_WORD_SOURCE_PARITY_EN
    cyc();
    push_word(8'h07);
    collect(0, W+1, d, p, s, f);
    chk("p07_data", d, 32'h07);
    chk("p07_par",  p, 1);
    cyc();
    push_word(8'h03);
    collect(0, W+1, d, p, s, f);
    chk("p03_data", d, 32'h03);
    chk("p03_par",  p, 0);
`endif

    // Reset mid-word with two words buffered
    repeat (2) cyc();
    push_word(8'h11);
    repeat (3) cyc();
    push_word(8'h22);
    push_word(8'h33);
    chk("pre_rst_busy", 32'(busy_m), 1);
    chk("pre_rst_rdy",  32'(rdy_m),  0);
    nReset = 1'b0;
    #1;
    chk("mid_rst_rdy",  32'(rdy_m | rdy_l),   0);
    chk("mid_rst_sv",   32'(sv_m | sv_l),     0);
    chk("mid_rst_sin",  32'(sin_m | sin_l),   0);
    chk("mid_rst_busy", 32'(busy_m | busy_l), 0);
    chk("mid_rst_pb",   32'(pb_m | pb_l),     0);
    repeat (2) cyc();
    nReset = 1'b1;
    repeat (20) begin
      @(negedge Clk);
      chk("post_rst_sv", 32'(sv_m | sv_l), 0);
    end
    cyc();
    push_word(8'h81);
    collect(0, W+PB, d, p, s, f);
    chk("post_rst_data", d, 32'h81);

    // Randomized traffic against the model, with one reset in the middle
    cyc();
    for (int i = 0; i < 2000; i++) begin
      DataValid = 1'($urandom_range(0, 1));
      DataIn    = W'($urandom);
      Enable    = ($urandom_range(0, 7) != 0);
      if (i == 1000) nReset = 1'b0;
      if (i == 1003) nReset = 1'b1;
      cyc();
    end
    DataValid = 1'b0;
    Enable    = 1'b1;
    repeat (40) cyc();
    chk("drain_busy", 32'(busy_m | busy_l), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
